// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder
//   Transmit end of the sprite command bus. Takes one sprite update at a
//   time and serialises it into four command words (VIS, X, Y, ATTR). At the
//   start of vertical blank it scans all 64 component IDs and sends a
//   buffer-swap word to each one updated during the frame. It keeps the
//   per-component front/back buffer bit so software does not have to.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   vcount[9:0]       : current VGA line, used to detect entry into vblank
//   upd_valid/ready   : update handshake
//   upd_component[5:0], upd_child[4:0], upd_visible, upd_flip,
//   upd_x/y/attr[9:0] : update payload, sampled on accept
//   writedata[31:0]   : registered command word (0 = NOP)
//   cmd_valid         : high while writedata is not a NOP
//   swap_done         : one-cycle pulse, concurrent with the last scan word
//   dbg_state[2:0]    : current FSM state
//
// Handshake: an update transfers on a rising edge where upd_valid and
// upd_ready are both high. upd_ready depends only on registered state, so it
// never depends combinationally on upd_valid. The payload must be stable
// while upd_valid is high.
//
// Word layout: [31:26] component, [25:21] child, [20:17] action,
//              [16:14] action type, [13] buffer toggle, [12:0] data.

module sprite_cmd_encoder #(
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  vcount,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [5:0]  upd_component,
  input  logic [4:0]  upd_child,
  input  logic        upd_visible,
  input  logic        upd_flip,
  input  logic [9:0]  upd_x,
  input  logic [9:0]  upd_y,
  input  logic [9:0]  upd_attr,
  output logic [31:0] writedata,
  output logic        cmd_valid,
  output logic        swap_done,
  output logic [2:0]  dbg_state
);

  // Each emit state names the word currently on writedata. SWAP means a
  // scan word (index scan_idx_q) is currently on writedata.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EMIT_V = 3'd1,
    S_EMIT_X = 3'd2,
    S_EMIT_Y = 3'd3,
    S_EMIT_A = 3'd4,
    S_SWAP   = 3'd5
  } state_e;

  localparam logic [3:0] ACT_UPDATE = 4'b0001;
  localparam logic [3:0] ACT_SWAP   = 4'b1111;
  localparam logic [2:0] TYPE_VIS   = 3'b001;
  localparam logic [2:0] TYPE_X     = 3'b010;
  localparam logic [2:0] TYPE_Y     = 3'b011;
  localparam logic [2:0] TYPE_ATTR  = 3'b100;
  localparam logic [5:0] LAST_IDX   = 6'd63;

  function automatic logic [31:0] make_word(
    input logic [5:0]  comp,
    input logic [4:0]  child,
    input logic [3:0]  action,
    input logic [2:0]  atype,
    input logic        tog,
    input logic [12:0] data
  );
    return {comp, child, action, atype, tog, data};
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  comp_q, comp_d;
  logic [4:0]  child_q, child_d;
  logic        tog_q, tog_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [9:0]  attr_q, attr_d;
  logic [5:0]  scan_idx_q, scan_idx_d;
  logic [63:0] front_q, front_d;
  logic [63:0] dirty_q, dirty_d;
  logic        pend_q, pend_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [31:0] writedata_q, writedata_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        swap_done_q, swap_done_d;

  logic        accept;
  logic        trigger;
  logic        start_scan;
  logic        scan_emit;
  logic [5:0]  scan_sel;

  assign upd_ready = ((state_q == S_IDLE) || (state_q == S_EMIT_A)) && !pend_q;
  assign accept    = upd_valid && upd_ready;
  assign trigger   = (vcount == VBLANK_LINE) && (vcount_q != VBLANK_LINE);

  always_comb begin
    state_d     = state_q;
    comp_d      = comp_q;
    child_d     = child_q;
    tog_d       = tog_q;
    x_d         = x_q;
    y_d         = y_q;
    attr_d      = attr_q;
    scan_idx_d  = scan_idx_q;
    front_d     = front_q;
    dirty_d     = dirty_q;
    pend_d      = pend_q;
    vcount_d    = vcount;
    writedata_d = 32'h0;
    swap_done_d = 1'b0;
    start_scan  = 1'b0;
    scan_emit   = 1'b0;
    scan_sel    = 6'd0;

    if (accept && (upd_component != 6'd0)) begin
      dirty_d[upd_component] = 1'b1;
    end

    // A vblank edge seen while scanning belongs to a frame already handled.
    if (trigger && (state_q != S_SWAP)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_EMIT_A: begin
        state_d = S_IDLE;
        if (accept) begin
          // ID 0 is consumed silently; everything else starts a burst.
          if (upd_component != 6'd0) begin
            comp_d      = upd_component;
            child_d     = upd_child;
            tog_d       = ~front_q[upd_component];
            x_d         = upd_x;
            y_d         = upd_y;
            attr_d      = upd_attr;
            writedata_d = make_word(upd_component, upd_child, ACT_UPDATE, TYPE_VIS,
                                    ~front_q[upd_component],
                                    {upd_visible, upd_flip, 11'd0});
            state_d     = S_EMIT_V;
          end
        end else if (pend_q) begin
          start_scan = 1'b1;
        end
      end
      S_EMIT_V: begin
        writedata_d = make_word(comp_q, child_q, ACT_UPDATE, TYPE_X, tog_q, {3'd0, x_q});
        state_d     = S_EMIT_X;
      end
      S_EMIT_X: begin
        writedata_d = make_word(comp_q, child_q, ACT_UPDATE, TYPE_Y, tog_q, {3'd0, y_q});
        state_d     = S_EMIT_Y;
      end
      S_EMIT_Y: begin
        writedata_d = make_word(comp_q, child_q, ACT_UPDATE, TYPE_ATTR, tog_q, {3'd0, attr_q});
        state_d     = S_EMIT_A;
      end
      S_SWAP: begin
        if (scan_idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          scan_idx_d  = scan_idx_q + 6'd1;
          scan_emit   = 1'b1;
          scan_sel    = scan_idx_q + 6'd1;
          // done pulses alongside the word for the final index
          swap_done_d = (scan_idx_q + 6'd1) == LAST_IDX;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_scan) begin
      state_d    = S_SWAP;
      scan_idx_d = 6'd0;
      pend_d     = 1'b0;
      scan_emit  = 1'b1;
      scan_sel   = 6'd0;
    end

    // The toggle names the buffer being promoted, then front flips so later
    // updates this component receives target the new back buffer.
    if (scan_emit && dirty_q[scan_sel]) begin
      writedata_d       = make_word(scan_sel, 5'd0, ACT_SWAP, 3'b000, ~front_q[scan_sel], 13'd0);
      dirty_d[scan_sel] = 1'b0;
      front_d[scan_sel] = ~front_q[scan_sel];
    end

    cmd_valid_d = (writedata_d != 32'h0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      comp_q      <= 6'd0;
      child_q     <= 5'd0;
      tog_q       <= 1'b0;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      attr_q      <= 10'd0;
      scan_idx_q  <= 6'd0;
      front_q     <= 64'd0;
      dirty_q     <= 64'd0;
      pend_q      <= 1'b0;
      vcount_q    <= 10'd0;
      writedata_q <= 32'h0;
      cmd_valid_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      comp_q      <= comp_d;
      child_q     <= child_d;
      tog_q       <= tog_d;
      x_q         <= x_d;
      y_q         <= y_d;
      attr_q      <= attr_d;
      scan_idx_q  <= scan_idx_d;
      front_q     <= front_d;
      dirty_q     <= dirty_d;
      pend_q      <= pend_d;
      vcount_q    <= vcount_d;
      writedata_q <= writedata_d;
      cmd_valid_q <= cmd_valid_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign writedata = writedata_q;
  assign cmd_valid = cmd_valid_q;
  assign swap_done = swap_done_q;
  assign dbg_state = state_q;

endmodule
